// File: rtl/uart_bus_master_if.sv
// Register-port bus between uart_bus_master (initiator) and the UART peripheral.
// Transfer phase is carried on wb_clk: high = request, low = release.
// wb_we uses write-low polarity: 0 = write, 1 = read.
interface uart_bus_master_if;
    logic [1:0] wb_addr;
    logic [7:0] wb_data_out;
    logic [7:0] wb_data_in;
    logic       wb_we;
    logic       wb_stb;
    logic       wb_clk;
    logic       wb_ack;

    modport master (
        output wb_addr, wb_data_out, wb_we, wb_stb, wb_clk,
        input  wb_data_in, wb_ack
    );

    modport slave (
        input  wb_addr, wb_data_out, wb_we, wb_stb, wb_clk,
        output wb_data_in, wb_ack
    );
endinterface

// File: rtl/uart_bus_master.sv
// Bus initiator for the UART register port (TX 0x0, RX 0x1, divider 0x2).
// Turns a byte stream, read requests and divider updates into single
// register transactions over the stb / phase-clock / ack handshake.
//
// Client handshakes (all requests are levels, sampled only in IDLE):
//  - tx_valid/tx_data: tx_ready is high for one cycle, the cycle after the
//    byte was taken; the source holds the byte until it sees tx_ready.
//  - rd_req: held until rd_ack (one cycle, rd_data valid with it); a read
//    that times out in REQ gives bus_err instead and the source may drop it.
//  - div_wr/div_data: taken when the divider transaction starts (wb_stb high
//    with wb_addr=2); div_cur follows only when the write completes.
//  - Peripheral: wb_stb/wb_clk rise together and hold addr/we/data until the
//    ack is seen; both fall together and the block waits for ack to drop.
module uart_bus_master #(
    parameter int         ACK_TIMEOUT = 64,
    parameter int         RD_HOLD     = 2,
    parameter logic [7:0] DIV_DEFAULT = 8'd78
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tx_valid,
    input  logic [7:0]               tx_data,
    output logic                     tx_ready,
    input  logic                     rd_req,
    output logic                     rd_ack,
    output logic [7:0]               rd_data,
    input  logic                     div_wr,
    input  logic [7:0]               div_data,
    output logic [7:0]               div_cur,
    output logic                     bus_err,
    output logic                     busy,
    output logic [2:0]               fsm_state,
    uart_bus_master_if.master        wb
);
    localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RD_HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        HOLD = 3'd2,
        REL  = 3'd3,
        GAP  = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    // Set when the current transaction timed out; suppresses completion pulses.
    logic             failed;

    assign fsm_state = state;

    // Transaction sequencer: arbitration, bus phases, timeouts and client pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            failed         <= 1'b0;
            wb.wb_stb      <= 1'b0;
            wb.wb_clk      <= 1'b0;
            wb.wb_we       <= 1'b1;
            wb.wb_addr     <= 2'd0;
            wb.wb_data_out <= 8'd0;
            tx_ready       <= 1'b0;
            rd_ack         <= 1'b0;
            rd_data        <= 8'd0;
            bus_err        <= 1'b0;
            busy           <= 1'b0;
            div_cur        <= DIV_DEFAULT;
        end else begin
            tx_ready <= 1'b0;
            rd_ack   <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    // A lingering ack from the previous transfer blocks a new start.
                    if (!wb.wb_ack && (div_wr || tx_valid || rd_req)) begin
                        state     <= REQ;
                        cnt       <= '0;
                        failed    <= 1'b0;
                        busy      <= 1'b1;
                        wb.wb_stb <= 1'b1;
                        wb.wb_clk <= 1'b1;
                        if (div_wr) begin
                            wb.wb_addr     <= 2'd2;
                            wb.wb_we       <= 1'b0;
                            wb.wb_data_out <= div_data;
                        end else if (tx_valid) begin
                            wb.wb_addr     <= 2'd0;
                            wb.wb_we       <= 1'b0;
                            wb.wb_data_out <= tx_data;
                            tx_ready       <= 1'b1;
                        end else begin
                            wb.wb_addr <= 2'd1;
                            wb.wb_we   <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (wb.wb_ack) begin
                        state <= HOLD;
                        cnt   <= CNT_W'(1);
                    end else if (cnt >= TMO_LAST) begin
                        state     <= REL;
                        cnt       <= '0;
                        failed    <= 1'b1;
                        bus_err   <= 1'b1;
                        wb.wb_stb <= 1'b0;
                        wb.wb_clk <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    // Writes release after one cycle; reads keep the phase high
                    // for RD_HOLD cycles and sample data in the last one.
                    if (!wb.wb_we || cnt >= HOLD_LAST) begin
                        if (wb.wb_we) begin
                            rd_data <= wb.wb_data_in;
                        end
                        state     <= REL;
                        cnt       <= '0;
                        wb.wb_stb <= 1'b0;
                        wb.wb_clk <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                REL: begin
                    if (!wb.wb_ack) begin
                        state <= GAP;
                        cnt   <= '0;
                        if (!failed) begin
                            if (wb.wb_we) begin
                                rd_ack <= 1'b1;
                            end
                            if (wb.wb_addr == 2'd2) begin
                                div_cur <= wb.wb_data_out;
                            end
                        end
                    end else if (cnt >= TMO_LAST) begin
                        state   <= GAP;
                        cnt     <= '0;
                        failed  <= 1'b1;
                        bus_err <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    busy      <= 1'b0;
                    wb.wb_stb <= 1'b0;
                    wb.wb_clk <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_bus_master.sv
// Testbench for uart_bus_master: a peripheral responder with per-transaction
// ack delay and read data, a bus monitor, and a reference model that predicts
// bus order, phase timing, read data, divider value and pulse counts.
module tb_uart_bus_master;
    localparam int         ACK_TIMEOUT = 64;
    localparam int         RD_HOLD     = 2;
    localparam logic [7:0] DIV_DEFAULT = 8'd78;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_ready;
    logic       rd_req = 1'b0;
    logic       rd_ack;
    logic [7:0] rd_data;
    logic       div_wr = 1'b0;
    logic [7:0] div_data = 8'd0;
    logic [7:0] div_cur;
    logic       bus_err;
    logic       busy;
    logic [2:0] fsm_state;

    uart_bus_master_if wb();

    uart_bus_master #(
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .RD_HOLD    (RD_HOLD),
        .DIV_DEFAULT(DIV_DEFAULT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rd_req   (rd_req),
        .rd_ack   (rd_ack),
        .rd_data  (rd_data),
        .div_wr   (div_wr),
        .div_data (div_data),
        .div_cur  (div_cur),
        .bus_err  (bus_err),
        .busy     (busy),
        .fsm_state(fsm_state),
        .wb       (wb)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [1:0] addr;
        logic       we;
        logic [7:0] data;
        logic [7:0] clk_hi;
        logic [7:0] hold_hi;
    } txn_t;

    typedef struct packed {
        logic [7:0] delay;
        logic [7:0] rdata;
    } plan_t;

    txn_t       exp_q[$];
    txn_t       obs_q[$];
    plan_t      plan_q[$];
    logic [7:0] exp_rd_q[$];

    int checks = 0;
    int failures = 0;
    int n_tx_ready = 0, n_rd_ack = 0, n_bus_err = 0, unstable = 0;
    int exp_tx_ready = 0, exp_rd_ack = 0, exp_bus_err = 0;
    logic [7:0] model_div = DIV_DEFAULT;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected bus record: a delay of 0 means the responder never acks.
    function automatic txn_t exp_txn(input logic [1:0] a, input logic we,
                                     input logic [7:0] d, input int dly);
        txn_t t;
        int   hold;
        hold      = we ? RD_HOLD : 1;
        t.addr    = a;
        t.we      = we;
        t.data    = d;
        t.clk_hi  = (dly == 0) ? 8'(ACK_TIMEOUT) : 8'(dly + hold);
        t.hold_hi = (dly == 0) ? 8'd0 : 8'(hold);
        return t;
    endfunction

    // ---------------- peripheral responder ----------------
    initial begin
        logic  active;
        int    cnt;
        plan_t p;
        active = 1'b0;
        cnt = 0;
        p = {8'd3, 8'h00};
        wb.wb_ack = 1'b0;
        wb.wb_data_in = 8'h00;
        forever begin
            @(negedge clk);
            if (wb.wb_stb && wb.wb_clk && !wb.wb_ack) begin
                if (!active) begin
                    active = 1'b1;
                    cnt = 0;
                    p = (plan_q.size() > 0) ? plan_q.pop_front() : {8'd3, 8'h00};
                    wb.wb_data_in = p.rdata;
                end
                cnt++;
                if (p.delay != 0 && cnt >= int'(p.delay)) wb.wb_ack = 1'b1;
            end else if (!wb.wb_clk) begin
                wb.wb_ack = 1'b0;
                active = 1'b0;
            end
        end
    end

    // ---------------- bus / pulse monitor ----------------
    initial begin
        logic in_txn;
        txn_t cur;
        in_txn = 1'b0;
        cur = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                in_txn = 1'b0;
            end else begin
                if (tx_ready) n_tx_ready++;
                if (bus_err) n_bus_err++;
                if (rd_ack) begin
                    n_rd_ack++;
                    if (exp_rd_q.size() == 0) check("rd_ack_unexpected", 1, 0);
                    else check("rd_data", rd_data, exp_rd_q.pop_front());
                end
                if (wb.wb_stb != wb.wb_clk) unstable++;
                if (wb.wb_stb && !in_txn) begin
                    in_txn = 1'b1;
                    cur.addr = wb.wb_addr;
                    cur.we = wb.wb_we;
                    cur.data = wb.wb_data_out;
                    cur.clk_hi = 8'd0;
                    cur.hold_hi = 8'd0;
                end
                if (in_txn) begin
                    if (wb.wb_stb && (wb.wb_addr != cur.addr || wb.wb_we != cur.we ||
                                      wb.wb_data_out != cur.data)) unstable++;
                    if (wb.wb_clk) cur.clk_hi++;
                    if (wb.wb_clk && wb.wb_ack) cur.hold_hi++;
                    if (!wb.wb_stb) begin
                        obs_q.push_back(cur);
                        in_txn = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic compare_bus();
        check("bus_count", obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            txn_t e;
            txn_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check("bus_addr", o.addr, e.addr);
            check("bus_we", o.we, e.we);
            if (!e.we) check("bus_data", o.data, e.data);
            check("bus_clk_hi", o.clk_hi, e.clk_hi);
            check("bus_hold_hi", o.hold_hi, e.hold_hi);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // Raise the chosen requests together; the model predicts order div, tx, rd.
    task automatic run_scenario(input logic do_div, input logic do_tx, input logic do_rd,
                                input logic [7:0] dv, input logic [7:0] tv,
                                input logic [7:0] rv, input int dd, input int dt,
                                input int dr);
        bit done;
        if (do_div) begin
            exp_q.push_back(exp_txn(2'd2, 1'b0, dv, dd));
            plan_q.push_back({8'(dd), 8'h00});
            if (dd != 0) model_div = dv;
            else exp_bus_err++;
        end
        if (do_tx) begin
            exp_q.push_back(exp_txn(2'd0, 1'b0, tv, dt));
            plan_q.push_back({8'(dt), 8'h00});
            exp_tx_ready++;
            if (dt == 0) exp_bus_err++;
        end
        if (do_rd) begin
            exp_q.push_back(exp_txn(2'd1, 1'b1, 8'h00, dr));
            plan_q.push_back({8'(dr), rv});
            if (dr != 0) begin
                exp_rd_q.push_back(rv);
                exp_rd_ack++;
            end else begin
                exp_bus_err++;
            end
        end
        @(negedge clk);
        div_wr = do_div;
        div_data = dv;
        tx_valid = do_tx;
        tx_data = tv;
        rd_req = do_rd;
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (tx_ready) tx_valid = 1'b0;
            if (rd_ack) rd_req = 1'b0;
            if (bus_err && wb.wb_addr == 2'd1) rd_req = 1'b0;
            if (wb.wb_stb && wb.wb_addr == 2'd2) div_wr = 1'b0;
            if (!tx_valid && !rd_req && !div_wr && !busy) done = 1'b1;
        end
        if (!done) begin
            check("scenario_timeout", 0, 1);
            tx_valid = 1'b0;
            rd_req = 1'b0;
            div_wr = 1'b0;
        end
        check("div_cur", div_cur, model_div);
        check("busy_idle", busy, 0);
        compare_bus();
    endtask

    function automatic int rand_delay();
        return ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int s;
        bit hit;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset values and a quiet idle bus.
        check("rst_stb", wb.wb_stb, 0);
        check("rst_clk", wb.wb_clk, 0);
        check("rst_we", wb.wb_we, 1);
        check("rst_addr", wb.wb_addr, 0);
        check("rst_data_out", wb.wb_data_out, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rd_ack", rd_ack, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_busy", busy, 0);
        check("rst_div_cur", div_cur, 78);
        s = 0;
        repeat (20) begin
            @(negedge clk);
            if (wb.wb_stb) s++;
        end
        check("idle_no_stb", s, 0);

        // TX byte, ack after 3 cycles.
        run_scenario(1'b0, 1'b1, 1'b0, 8'h00, 8'h41, 8'h00, 0, 3, 0);
        check("tx_ready_once", n_tx_ready, 1);

        // RX read returning 0x5A.
        run_scenario(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h5A, 0, 0, 3);
        check("rd_data_5a", rd_data, 8'h5A);

        // All three at once: divider, then TX, then RX.
        run_scenario(1'b1, 1'b1, 1'b1, 8'h0C, 8'h33, 8'hC3, 2, 1, 4);
        check("div_cur_0c", div_cur, 8'h0C);

        // Read that is never acked, then a normal transfer.
        run_scenario(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h11, 0, 0, 0);
        check("timeout_rd_data_kept", rd_data, 8'hC3);
        run_scenario(1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 8'h00, 0, 2, 0);

        // Reset while the read is holding its phase high.
        plan_q.push_back({8'd3, 8'h77});
        @(negedge clk);
        rd_req = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (wb.wb_ack && wb.wb_clk) hit = 1'b1;
        end
        check("hold_reached", hit, 1);
        @(negedge clk);
        reset = 1'b1;
        rd_req = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_stb", wb.wb_stb, 0);
        check("mid_rst_clk", wb.wb_clk, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rd_ack", rd_ack, 0);
        check("mid_rst_tx_ready", tx_ready, 0);
        check("mid_rst_bus_err", bus_err, 0);
        check("mid_rst_div_cur", div_cur, 78);
        model_div = DIV_DEFAULT;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_busy", busy, 0);
        obs_q.delete();

        // Randomized mixes of the three request kinds.
        for (int n = 0; n < 30; n++) begin
            logic ddv, dtx, drd;
            ddv = 1'($urandom_range(0, 1));
            dtx = 1'($urandom_range(0, 1));
            drd = 1'($urandom_range(0, 1));
            if (!ddv && !dtx && !drd) dtx = 1'b1;
            run_scenario(ddv, dtx, drd, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                         8'($urandom_range(0, 255)), rand_delay(), rand_delay(), rand_delay());
        end

        repeat (5) @(negedge clk);
        check("total_tx_ready", n_tx_ready, exp_tx_ready);
        check("total_rd_ack", n_rd_ack, exp_rd_ack);
        check("total_bus_err", n_bus_err, exp_bus_err);
        check("bus_stable", unstable, 0);
        check("rd_q_drained", exp_rd_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
